// File: rtl/pc_nzp_unit.sv
// pc_nzp_unit: next-PC selection (seq/branch/call/ret) with NZP flag register and bounded return stack.
module pc_nzp_unit #(
    parameter int PROGRAM_ADDR_BITS = 8,
    parameter int DATA_BITS         = 8,
    parameter int STACK_DEPTH       = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic [2:0]                           core_state,
    input  logic [1:0]                           decoded_pc_mux,
    input  logic [2:0]                           decoded_nzp,
    input  logic [PROGRAM_ADDR_BITS-1:0]         decoded_immediate,
    input  logic                                 decoded_nzp_write_enable,
    input  logic [DATA_BITS-1:0]                 alu_out,
    input  logic [PROGRAM_ADDR_BITS-1:0]         current_pc,
    output logic [PROGRAM_ADDR_BITS-1:0]         next_pc,
    output logic [2:0]                           nzp,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_count,
    output logic                                 stack_error
);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0] EXECUTE = 3'b101;
    localparam logic [2:0] UPDATE  = 3'b110;
    localparam logic [1:0] BRANCH  = 2'b01;
    localparam logic [1:0] CALL    = 2'b10;
    localparam logic [1:0] RET     = 2'b11;

    logic [PROGRAM_ADDR_BITS-1:0] r_stack [STACK_DEPTH];
    logic [PROGRAM_ADDR_BITS-1:0] r_next_pc;
    logic [2:0]                   r_nzp;
    logic [CW-1:0]                r_count;
    logic                         r_error;

    logic                         w_exec, w_upd, w_full, w_empty, w_taken;
    logic                         w_push, w_pop, w_err, w_unused_alu;
    logic [PROGRAM_ADDR_BITS-1:0] w_pc_inc, w_pc_d;
    logic [SW-1:0]                w_top;

    // Gating with reset keeps the stack array from being written while reset is held.
    assign w_exec       = reset && enable && core_state == EXECUTE;
    assign w_upd        = reset && enable && core_state == UPDATE && decoded_nzp_write_enable;
    assign w_full       = r_count == CW'(STACK_DEPTH);
    assign w_empty      = r_count == '0;
    assign w_taken      = |(r_nzp & decoded_nzp);
    assign w_pc_inc     = current_pc + PROGRAM_ADDR_BITS'(1);
    assign w_push       = w_exec && decoded_pc_mux == CALL && !w_full;
    assign w_pop        = w_exec && decoded_pc_mux == RET && !w_empty;
    assign w_err        = w_exec && ((decoded_pc_mux == CALL && w_full) || (decoded_pc_mux == RET && w_empty));
    assign w_top        = SW'(r_count - CW'(1));
    assign w_unused_alu = ^alu_out;

    always_comb begin
        w_pc_d = w_pc_inc;
        if (decoded_pc_mux == BRANCH)
            w_pc_d = w_taken ? decoded_immediate : w_pc_inc;
        else if (decoded_pc_mux == CALL)
            w_pc_d = w_full ? w_pc_inc : decoded_immediate;
        else if (decoded_pc_mux == RET)
            w_pc_d = w_empty ? w_pc_inc : r_stack[w_top];
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_stack[SW'(r_count)] <= w_pc_inc;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_next_pc <= '0;
            r_nzp     <= '0;
            r_count   <= '0;
            r_error   <= 1'b0;
        end else begin
            if (w_exec)
                r_next_pc <= w_pc_d;
            if (w_push)
                r_count <= r_count + CW'(1);
            else if (w_pop)
                r_count <= r_count - CW'(1);
            if (w_err)
                r_error <= 1'b1;
            if (w_upd)
                r_nzp <= alu_out[2:0];
        end
    end

    assign next_pc     = r_next_pc;
    assign nzp         = r_nzp;
    assign stack_count = r_count;
    assign stack_error = r_error;
endmodule

// File: tb/tb_pc_nzp_unit.sv
// tb_pc_nzp_unit: directed and random checks of pc_nzp_unit against a queue-based reference model.
module tb_pc_nzp_unit;
    localparam logic [2:0] EX = 3'b101;
    localparam logic [2:0] UP = 3'b110;
    localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, CALL = 2'b10, RET = 2'b11;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] core_state = 3'b000;
    logic [1:0] decoded_pc_mux = 2'b00;
    logic [2:0] decoded_nzp = 3'b000;
    logic [7:0] decoded_immediate = 8'h00;
    logic       decoded_nzp_write_enable = 1'b0;
    logic [7:0] alu_out = 8'h00;
    logic [7:0] current_pc = 8'h00;
    logic [7:0] next_pc;
    logic [2:0] nzp;
    logic [2:0] stack_count;
    logic       stack_error;

    int errors = 0;
    int checks = 0;
    int m_pc, m_nzp, m_err;
    int m_stk[$];

    pc_nzp_unit dut (
        .clock(clock), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_pc_mux(decoded_pc_mux), .decoded_nzp(decoded_nzp),
        .decoded_immediate(decoded_immediate),
        .decoded_nzp_write_enable(decoded_nzp_write_enable),
        .alu_out(alu_out), .current_pc(current_pc), .next_pc(next_pc), .nzp(nzp),
        .stack_count(stack_count), .stack_error(stack_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".next_pc"}, {24'd0, next_pc}, m_pc);
        chk({tag, ".nzp"}, {29'd0, nzp}, m_nzp);
        chk({tag, ".stack_count"}, {29'd0, stack_count}, m_stk.size());
        chk({tag, ".stack_error"}, {31'd0, stack_error}, m_err);
    endtask

    task automatic model_clear();
        m_pc = 0; m_nzp = 0; m_err = 0;
        m_stk.delete();
    endtask

    // Reference behaviour computed from the pre-edge model state and current inputs.
    task automatic model_step();
        int inc;
        inc = (int'(current_pc) + 1) % 256;
        if (!enable) return;
        if (core_state == UP && decoded_nzp_write_enable) m_nzp = alu_out % 8;
        if (core_state != EX) return;
        case (decoded_pc_mux)
            SEQ: m_pc = inc;
            BR:  m_pc = ((m_nzp & decoded_nzp) != 0) ? int'(decoded_immediate) : inc;
            CALL: if (m_stk.size() < 4) begin m_stk.push_back(inc); m_pc = decoded_immediate; end
                  else begin m_pc = inc; m_err = 1; end
            default: if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                     else begin m_pc = inc; m_err = 1; end
        endcase
    endtask

    task automatic drive(input logic en, input logic [2:0] cs, input logic [1:0] mux,
                         input logic [2:0] dn, input logic [7:0] imm, input logic we,
                         input logic [7:0] alu, input logic [7:0] pc);
        enable = en; core_state = cs; decoded_pc_mux = mux; decoded_nzp = dn;
        decoded_immediate = imm; decoded_nzp_write_enable = we; alu_out = alu; current_pc = pc;
    endtask

    task automatic cycle(input string tag);
        if (reset) model_step();
        @(posedge clock);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        model_clear();
        compare_all(tag);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        model_clear();
        #2;
        compare_all("reset_state");
        @(posedge clock); #1;
        reset = 1'b1;

        drive(1, UP, SEQ, 3'b000, 8'h00, 1, 8'b0000_0100, 8'h00); cycle("flag_latch");
        chk("flag_latch.spec", {29'd0, nzp}, 3'b100);
        drive(1, EX, BR, 3'b100, 8'h40, 0, 8'h00, 8'h10); cycle("br_taken");
        chk("br_taken.spec", {24'd0, next_pc}, 'h40);

        drive(1, UP, SEQ, 3'b000, 8'h00, 1, 8'h02, 8'h00); cycle("nzp_z");
        drive(1, EX, BR, 3'b101, 8'h40, 0, 8'h00, 8'h10); cycle("br_not_taken");
        chk("br_not_taken.spec", {24'd0, next_pc}, 'h11);

        drive(1, EX, SEQ, 3'b000, 8'h00, 0, 8'h00, 8'hFF); cycle("seq_wrap");
        chk("seq_wrap.spec", {24'd0, next_pc}, 'h00);

        drive(1, EX, CALL, 3'b000, 8'h20, 0, 8'h00, 8'h05); cycle("call1");
        chk("call1.spec", {24'd0, next_pc}, 'h20);
        drive(1, EX, CALL, 3'b000, 8'h30, 0, 8'h00, 8'h22); cycle("call2");
        chk("call2.count", {29'd0, stack_count}, 2);
        drive(1, EX, RET, 3'b000, 8'h00, 0, 8'h00, 8'h31); cycle("ret1");
        chk("ret1.spec", {24'd0, next_pc}, 'h23);
        drive(1, EX, RET, 3'b000, 8'h00, 0, 8'h00, 8'h24); cycle("ret2");
        chk("ret2.spec", {24'd0, next_pc}, 'h06);
        chk("ret2.err", {31'd0, stack_error}, 0);

        for (int i = 0; i < 5; i++) begin
            drive(1, EX, CALL, 3'b000, 8'(8'h60 + i), 0, 8'h00, 8'(8'h50 + i));
            cycle("call_fill");
        end
        chk("overflow.pc", {24'd0, next_pc}, 'h55);
        chk("overflow.count", {29'd0, stack_count}, 4);
        chk("overflow.err", {31'd0, stack_error}, 1);

        do_reset("reset_underflow");
        drive(1, EX, RET, 3'b000, 8'h00, 0, 8'h00, 8'h08); cycle("underflow");
        chk("underflow.pc", {24'd0, next_pc}, 'h09);
        chk("underflow.err", {31'd0, stack_error}, 1);

        drive(1, EX, SEQ, 3'b000, 8'h00, 0, 8'h00, 8'h33); cycle("pre_hold");
        for (int i = 0; i < 3; i++) begin
            drive(0, EX, SEQ, 3'b000, 8'h00, 1, 8'h07, 8'(8'h80 + i));
            cycle("enable_hold");
        end
        chk("enable_hold.spec", {24'd0, next_pc}, 'h34);

        do_reset("reset_pre_stack");
        drive(1, EX, CALL, 3'b000, 8'h10, 0, 8'h00, 8'h01); cycle("stk_a");
        drive(1, EX, CALL, 3'b000, 8'h20, 0, 8'h00, 8'h11); cycle("stk_b");
        drive(1, UP, SEQ, 3'b000, 8'h00, 1, 8'h01, 8'h00); cycle("nzp_p");
        @(negedge clock);
        drive(1, EX, CALL, 3'b000, 8'h71, 0, 8'h00, 8'h70);
        reset = 1'b0;
        #1;
        model_clear();
        compare_all("async_reset");
        @(posedge clock); #1;
        compare_all("reset_held_edge");
        reset = 1'b1;
        cycle("post_reset_edge");
        chk("post_reset_edge.spec", {24'd0, next_pc}, 'h71);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] cs;
            case ($urandom_range(0, 3))
                0, 1: cs = EX;
                2: cs = UP;
                default: cs = 3'($urandom);
            endcase
            drive(1'($urandom_range(0, 9) != 0), cs, 2'($urandom), 3'($urandom), 8'($urandom),
                  1'($urandom), 8'($urandom), 8'($urandom));
            cycle("random");
            if (i == 200) do_reset("random_reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
